uart_frame_rx: RTL and testbench
================================

// Module: uart_frame_rx
//
// PURPOSE
//   Receive-side parser for the 4-byte frame-counter packet sent over the debug UART:
//   byte order 0xAA, count[15:8], count[7:0], 0x55.
//   Sits between the UART rx_data/rx_data_valid byte stream and consumer logic.
//   Recovers the 16-bit frame count and presents it on a valid/ack handshake.
//   Also detects framing errors, inter-byte timeouts and consumer overruns.
//
// PARAMETERS
//   HEADER          8'hAA  first byte of a packet
//   TRAILER         8'h55  last byte of a packet
//   TIMEOUT_CYCLES  1024   max clk cycles between bytes inside a packet (min 2)
//
// PORTS
//   clk              in   1   UART clock domain (1.8432 MHz)
//   rst              in   1   asynchronous, active-low reset
//   rx_data          in   8   received byte from UART
//   rx_data_valid    in   1   one-cycle strobe; rx_data is valid this cycle
//   frame_count      out  16  decoded count {hi,lo}; stable while frame_count_valid=1
//   frame_count_valid out 1   decoded packet pending
//   frame_count_ack  in   1   consumer accepts the pending packet
//   frame_err_count  out  8   saturating count of bad-trailer and timeout aborts
//   overrun_count    out  8   saturating count of packets dropped while one was pending
//
// BEHAVIOUR
//   Reset (rst=0, async): all outputs are 0; state=HUNT; timeout counter=0.
//   FSM advances only on cycles with rx_data_valid=1, except for timeouts.
//     HUNT : byte==HEADER -> HI; any other byte is discarded silently (no error).
//     HI   : capture hi byte -> LO.
//     LO   : capture lo byte -> TRAIL.
//     TRAIL: byte==TRAILER -> packet complete -> HUNT.
//            byte==HEADER  -> frame_err_count+1 -> HI (resync on new header).
//            any other     -> frame_err_count+1 -> HUNT.
//   Header bytes seen in HI or LO are data, not resync.
//   Timeout: in HI/LO/TRAIL, the counter increments every cycle without rx_data_valid.
//     It clears on each valid byte and in HUNT.
//     On reaching TIMEOUT_CYCLES: -> HUNT, frame_err_count+1, partial data discarded.
//     A byte arriving in the same cycle as the timeout wins: no timeout is taken.
//   Output handshake:
//     On packet complete, frame_count_valid=1 and frame_count={hi,lo} from the next cycle.
//     Latency is 1 clk after the trailer strobe.
//     valid is held, and frame_count is held stable, until a cycle where valid&ack=1.
//     valid clears the cycle after that, unless a new packet completes in that same cycle.
//     Simultaneous ack and completion: the new packet is loaded and valid stays 1.
//     Completion while valid=1 and ack=0: the new packet is dropped, overrun_count+1.
//       The pending value is not overwritten.
//     ack while valid=0 is ignored.
//   Counters saturate at 8'hFF and do not wrap. They are cleared only by reset.
//   Reset asserted mid-packet or mid-handshake: the pending value is lost.
//     After deassertion the FSM restarts in HUNT.
//
// TESTING
//   1. AA 12 34 55 strobed 160 clk apart, ack held 1
//      -> frame_count=16'h1234, valid for 1 cycle, 1 clk after the 0x55 strobe.
//   2. 00 AA 12 34 77 -> no valid, frame_err_count=1.
//      Then AA 56 78 55 -> frame_count=16'h5678.
//   3. AA 01 02 AA 03 04 55 -> frame_err_count=1, frame_count=16'h0304 (resync path).
//   4. AA 9A then 1024 idle cycles -> frame_err_count=1, state HUNT.
//      Then 55 arrives -> no valid.
//   5. ack=0; packets 0x0001 then 0x0002 -> frame_count stays 16'h0001, overrun_count=1.
//      Ack, then packet 0x0003 -> frame_count=16'h0003.
//   6. Trailer strobe in the same cycle as ack of 0x1111, new packet 0x2222
//      -> valid stays 1, frame_count=16'h2222.
//      Also: rst pulsed low after AA 12 -> all outputs 0, and 34 55 yields no valid.

Source files
------------

// File: rtl/uart_frame_rx.sv
// Parser for the 4-byte frame-counter packet (HEADER, count[15:8], count[7:0], TRAILER)
// arriving on the debug UART byte stream; presents the count on a valid/ack handshake.
module uart_frame_rx #(
    parameter logic [7:0] HEADER         = 8'hAA,
    parameter logic [7:0] TRAILER        = 8'h55,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    output logic [15:0] frame_count,
    output logic        frame_count_valid,
    input  logic        frame_count_ack,
    output logic [7:0]  frame_err_count,
    output logic [7:0]  overrun_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {HUNT, HI, LO, TRAIL} state_t;

    state_t        state, state_next;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    hi_byte, lo_byte;
    logic          take_hi, take_lo, complete, frame_err, timeout;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        take_hi    = 1'b0;
        take_lo    = 1'b0;
        complete   = 1'b0;
        frame_err  = 1'b0;
        timeout    = 1'b0;
        case (state)
            HUNT:  if (rx_data_valid && rx_data == HEADER) state_next = HI;
            HI:    if (rx_data_valid) begin take_hi = 1'b1; state_next = LO; end
            LO:    if (rx_data_valid) begin take_lo = 1'b1; state_next = TRAIL; end
            TRAIL: if (rx_data_valid) begin
                if (rx_data == TRAILER) begin
                    complete   = 1'b1;
                    state_next = HUNT;
                end else begin
                    frame_err  = 1'b1;
                    state_next = (rx_data == HEADER) ? HI : HUNT;
                end
            end
            default: state_next = HUNT;
        endcase
        // A byte in the expiry cycle wins, so only idle cycles can time out.
        if (state != HUNT && !rx_data_valid && tmo_cnt == TMO_LAST) begin
            timeout    = 1'b1;
            frame_err  = 1'b1;
            state_next = HUNT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= HUNT;
            tmo_cnt <= '0;
            hi_byte <= '0;
            lo_byte <= '0;
        end else begin
            state <= state_next;
            if (state == HUNT || rx_data_valid || timeout) tmo_cnt <= '0;
            else                                           tmo_cnt <= tmo_cnt + TW'(1);
            if (take_hi) hi_byte <= rx_data;
            if (take_lo) lo_byte <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_count       <= '0;
            frame_count_valid <= 1'b0;
            frame_err_count   <= '0;
            overrun_count     <= '0;
        end else begin
            if (complete && (!frame_count_valid || frame_count_ack)) begin
                frame_count       <= {hi_byte, lo_byte};
                frame_count_valid <= 1'b1;
            end else if (complete) begin
                if (overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
            end else if (frame_count_valid && frame_count_ack) begin
                frame_count_valid <= 1'b0;
            end
            if (frame_err && frame_err_count != 8'hFF) frame_err_count <= frame_err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: table vectors, hand-written corner sequences and
// randomized packet traffic compared every cycle against a byte-queue reference model.
module tb_uart_frame_rx;

    localparam int TMO = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_data_valid = 1'b0;
    logic        frame_count_ack = 1'b0;
    logic [15:0] frame_count;
    logic        frame_count_valid;
    logic [7:0]  frame_err_count;
    logic [7:0]  overrun_count;

    int checks = 0;
    int errors = 0;

    uart_frame_rx #(.HEADER(8'hAA), .TRAILER(8'h55), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_data_valid(rx_data_valid),
        .frame_count(frame_count),
        .frame_count_valid(frame_count_valid),
        .frame_count_ack(frame_count_ack),
        .frame_err_count(frame_err_count),
        .overrun_count(overrun_count)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Reference model: bytes of the packet in progress, idle-cycle count, pending output.
    logic [7:0]  part[$];
    int          m_idle;
    bit          m_pend;
    logic [15:0] m_val;
    int          m_err;
    int          m_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int x);
        return (x > 255) ? 255 : x;
    endfunction

    task automatic model_reset();
        part.delete();
        m_idle = 0;
        m_pend = 1'b0;
        m_val  = 16'h0000;
        m_err  = 0;
        m_ovr  = 0;
    endtask

    task automatic model_cycle(input bit v, input logic [7:0] d, input bit a);
        bit          done;
        logic [15:0] pkt;
        done = 1'b0;
        pkt  = 16'h0000;
        if (v) begin
            m_idle = 0;
            if (part.size() == 0) begin
                if (d == 8'hAA) part.push_back(d);
            end else if (part.size() < 3) begin
                part.push_back(d);
            end else begin
                if (d == 8'h55) begin
                    done = 1'b1;
                    pkt  = {part[1], part[2]};
                    part.delete();
                end else begin
                    m_err = sat(m_err + 1);
                    part.delete();
                    if (d == 8'hAA) part.push_back(d);
                end
            end
        end else if (part.size() != 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_err = sat(m_err + 1);
                part.delete();
                m_idle = 0;
            end
        end
        if (done) begin
            if (!m_pend || a) begin
                m_pend = 1'b1;
                m_val  = pkt;
            end else begin
                m_ovr = sat(m_ovr + 1);
            end
        end else if (m_pend && a) begin
            m_pend = 1'b0;
        end
    endtask

    task automatic compare_model();
        check("m_valid", 32'(frame_count_valid), 32'(m_pend));
        if (m_pend) check("m_count", 32'(frame_count), 32'(m_val));
        check("m_err", 32'(frame_err_count), m_err);
        check("m_ovr", 32'(overrun_count), m_ovr);
    endtask

    function automatic bit ack_bit(input int mode);
        if (mode == 2) return 1'($urandom_range(0, 1));
        return mode[0];
    endfunction

    // One clock: drive inputs just after an edge, advance model at the next edge, sample 1 ns later.
    task automatic step(input bit v, input logic [7:0] d, input bit a);
        rx_data_valid   = v;
        rx_data         = v ? d : 8'($urandom);
        frame_count_ack = a;
        @(posedge clk);
        model_cycle(v, d, a);
        #1;
        compare_model();
    endtask

    task automatic idle(input int n, input int ackm);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, ack_bit(ackm));
    endtask

    task automatic send_seq(input logic [79:0] bytes, input int n, input int gap, input int ackm);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = bytes[8*(n-1-i) +: 8];
            step(1'b1, b, ack_bit(ackm));
            if (i < n - 1) idle(gap, ackm);
        end
    endtask

    task automatic send_pkt(input logic [15:0] val, input int ackm);
        send_seq({48'h0, 8'hAA, val, 8'h55}, 4, 0, ackm);
    endtask

    task automatic do_reset();
        rx_data_valid   = 1'b0;
        frame_count_ack = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        check("rst_count", 32'(frame_count), 32'h0);
        check("rst_valid", 32'(frame_count_valid), 32'h0);
        check("rst_err", 32'(frame_err_count), 32'h0);
        check("rst_ovr", 32'(overrun_count), 32'h0);
        rst = 1'b1;
    endtask

    typedef struct {
        logic [79:0] bytes;
        int          n;
        int          gap;
        bit          ack;
        logic [15:0] e_count;
        bit          e_valid;
        logic [7:0]  e_err;
        logic [7:0]  e_ovr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{80'hAA_12_34_55, 4, 159, 1'b1, 16'h1234, 1'b1, 8'd0, 8'd0};
        vecs[1] = '{80'h00_AA_12_34_77_AA_56_78_55, 9, 2, 1'b1, 16'h5678, 1'b1, 8'd1, 8'd0};
        vecs[2] = '{80'hAA_01_02_AA_03_04_55, 7, 1, 1'b1, 16'h0304, 1'b1, 8'd1, 8'd0};
        vecs[3] = '{80'hAA_34_12, 3, 0, 1'b0, 16'h0000, 1'b0, 8'd0, 8'd0};
        vecs[4] = '{80'hAA_AA_55_55, 4, 3, 1'b0, 16'hAA55, 1'b1, 8'd0, 8'd0};
        vecs[5] = '{80'h55_AA_00_00_AA_AA_01_02_55, 9, 0, 1'b1, 16'h0000, 1'b0, 8'd2, 8'd0};

        for (int i = 0; i < 6; i++) begin
            do_reset();
            send_seq(vecs[i].bytes, vecs[i].n, vecs[i].gap, int'(vecs[i].ack));
            check($sformatf("vec%0d_count", i), 32'(frame_count), 32'(vecs[i].e_count));
            check($sformatf("vec%0d_valid", i), 32'(frame_count_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_err", i), 32'(frame_err_count), 32'(vecs[i].e_err));
            check($sformatf("vec%0d_ovr", i), 32'(overrun_count), 32'(vecs[i].e_ovr));
            step(1'b0, 8'h00, vecs[i].ack);
            if (vecs[i].ack && vecs[i].e_valid)
                check($sformatf("vec%0d_one_cycle", i), 32'(frame_count_valid), 32'h0);
        end

        // Timeout: 1023 idle cycles survive, the 1024th aborts; then a lone trailer is ignored.
        do_reset();
        send_seq(80'hAA_9A, 2, 0, 0);
        idle(TMO - 1, 0);
        check("tmo_edge_err", 32'(frame_err_count), 32'h0);
        idle(1, 0);
        check("tmo_err", 32'(frame_err_count), 32'h1);
        step(1'b1, 8'h55, 1'b0);
        check("tmo_no_valid", 32'(frame_count_valid), 32'h0);
        send_seq(80'hAA_9A, 2, 0, 0);
        idle(TMO - 1, 0);
        send_seq(80'h34_55, 2, 0, 0);
        check("tmo_byte_wins_valid", 32'(frame_count_valid), 32'h1);
        check("tmo_byte_wins_count", 32'(frame_count), 32'h9A34);
        check("tmo_byte_wins_err", 32'(frame_err_count), 32'h1);

        // Overrun while pending, then ack and reload.
        do_reset();
        send_pkt(16'h0001, 0);
        send_pkt(16'h0002, 0);
        check("ovr_count", 32'(frame_count), 32'h0001);
        check("ovr_valid", 32'(frame_count_valid), 32'h1);
        check("ovr_ovr", 32'(overrun_count), 32'h1);
        step(1'b0, 8'h00, 1'b1);
        check("ovr_ack_clears", 32'(frame_count_valid), 32'h0);
        send_pkt(16'h0003, 0);
        check("ovr_reload", 32'(frame_count), 32'h0003);

        // Ack coincides with the trailer of the next packet.
        do_reset();
        send_pkt(16'h1111, 0);
        send_seq(80'hAA_22_22, 3, 0, 0);
        step(1'b1, 8'h55, 1'b1);
        check("ackcomp_valid", 32'(frame_count_valid), 32'h1);
        check("ackcomp_count", 32'(frame_count), 32'h2222);
        check("ackcomp_ovr", 32'(overrun_count), 32'h0);
        step(1'b0, 8'h00, 1'b0);
        check("ackcomp_hold", 32'(frame_count_valid), 32'h1);

        // Reset pulsed mid-packet with a value pending.
        send_seq(80'hAA_12, 2, 0, 0);
        rst = 1'b0;
        #3;
        check("midrst_count", 32'(frame_count), 32'h0);
        check("midrst_valid", 32'(frame_count_valid), 32'h0);
        check("midrst_err", 32'(frame_err_count), 32'h0);
        check("midrst_ovr", 32'(overrun_count), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        send_seq(80'h34_55, 2, 0, 0);
        check("midrst_no_valid", 32'(frame_count_valid), 32'h0);

        // Saturation of both counters.
        do_reset();
        send_pkt(16'h0101, 0);
        for (int i = 0; i < 258; i++) send_pkt(16'(i), 0);
        check("sat_ovr", 32'(overrun_count), 32'hFF);
        check("sat_held", 32'(frame_count), 32'h0101);
        for (int i = 0; i < 258; i++) send_seq(80'hAA_00_00_00, 4, 0, 0);
        check("sat_err", 32'(frame_err_count), 32'hFF);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 55)
                send_seq({48'h0, 8'hAA, 16'($urandom), 8'h55}, 4, $urandom_range(0, 3), 2);
            else if (r < 75)
                step(1'b1, ($urandom_range(0, 2) == 0) ? 8'hAA : 8'($urandom), ack_bit(2));
            else if (r < 90)
                send_seq({48'h0, 8'hAA, 16'($urandom), 8'($urandom)}, 4, $urandom_range(0, 2), 2);
            else if (r < 95)
                idle($urandom_range(1, 40), 2);
            else begin
                send_seq({64'h0, 8'hAA, 8'($urandom)}, 2, 0, 2);
                idle($urandom_range(TMO - 24, TMO + 6), 2);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
